// File: rtl/pixel_fifo_pkg.sv
// pixel_fifo_pkg: shared constants, pixel record type and width helpers for the pixel FIFO
// Contents:
//   PIX_DATA_WIDTH / PIX_DEPTH / PIX_NUM_ENGINES - defaults shared with the engine array
//   pixel_rec_t - one pixel record {x, depth}
//   ptr_w / lvl_w / idx_w / cnt_w - $clog2 wrappers for pointer, level, engine index and grant count widths
package pixel_fifo_pkg;

    localparam int PIX_DATA_WIDTH  = 20;
    localparam int PIX_DEPTH       = 32;
    localparam int PIX_NUM_ENGINES = 5;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] depth;
    } pixel_rec_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pixel_fifo_rr_alloc.sv
// pixel_fifo_rr_alloc: combinational round-robin slot allocator for the multi-writer pixel FIFO
// Ports:
//   req_i     - per-engine write requests
//   rr_ptr_i  - engine scanned first this cycle
//   free_i    - free FIFO slots
//   grant_o   - per-engine grants (first min(free, requests) requesters in scan order)
//   offset_o  - per-engine write offset from wr_ptr (scan-order rank), OFF_W bits each
//   count_o   - number of grants
//   rr_next_o - engine after the last one granted, or rr_ptr_i when nothing is granted
module pixel_fifo_rr_alloc
    import pixel_fifo_pkg::*;
#(
    parameter int NUM_ENGINES = PIX_NUM_ENGINES,
    parameter int OFF_W       = ptr_w(PIX_DEPTH),
    parameter int FREE_W      = lvl_w(PIX_DEPTH)
) (
    input  logic [NUM_ENGINES-1:0]         req_i,
    input  logic [idx_w(NUM_ENGINES)-1:0]  rr_ptr_i,
    input  logic [FREE_W-1:0]              free_i,
    output logic [NUM_ENGINES-1:0]         grant_o,
    output logic [NUM_ENGINES*OFF_W-1:0]   offset_o,
    output logic [cnt_w(NUM_ENGINES)-1:0]  count_o,
    output logic [idx_w(NUM_ENGINES)-1:0]  rr_next_o
);

    localparam int RW = idx_w(NUM_ENGINES);
    localparam int CW = cnt_w(NUM_ENGINES);

    // Each engine's rank is the number of requesters ahead of it in scan order;
    // engines whose rank is below free form the granted prefix and rank doubles as write offset.
    always_comb begin
        int pos  [NUM_ENGINES];
        int rank [NUM_ENGINES];
        int n;
        grant_o   = '0;
        offset_o  = '0;
        rr_next_o = rr_ptr_i;
        n         = 0;
        for (int i = 0; i < NUM_ENGINES; i++)
            pos[i] = (i >= int'(rr_ptr_i)) ? i - int'(rr_ptr_i) : i + NUM_ENGINES - int'(rr_ptr_i);
        for (int i = 0; i < NUM_ENGINES; i++) begin
            rank[i] = 0;
            for (int j = 0; j < NUM_ENGINES; j++)
                if (req_i[j] && pos[j] < pos[i])
                    rank[i] = rank[i] + 1;
            if (req_i[i] && rank[i] < int'(free_i)) begin
                grant_o[i]                  = 1'b1;
                offset_o[i*OFF_W +: OFF_W]  = OFF_W'(rank[i]);
                n                           = n + 1;
            end
        end
        count_o = CW'(n);
        for (int i = 0; i < NUM_ENGINES; i++)
            if (grant_o[i] && rank[i] == n - 1)
                rr_next_o = (i == NUM_ENGINES - 1) ? '0 : RW'(i + 1);
    end

endmodule

// File: rtl/pixel_fifo_mw.sv
// pixel_fifo_mw: multi-writer, single-reader FWFT pixel FIFO merging NUM_ENGINES engine streams
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - synchronous active-low reset
//   wr_data   - flat write bus, engine i at [DATA_WIDTH*i +: DATA_WIDTH]
//   wr_valid  - per-engine write request
//   wr_ready  - per-engine grant (depends combinationally on wr_valid)
//   rd_valid  - FIFO not empty
//   rd_data   - head entry (first-word fall-through)
//   rd_ready  - consumer pop
//   level     - occupancy
//   afull     - level >= AFULL_THRESH
//   full      - level == DEPTH
// Optional (PIXEL_FIFO_STATS_EN defined):
//   stall_cnt - saturating count of refused requests (valid && !ready), per engine per cycle
//   hwm       - highest level seen since reset
module pixel_fifo_mw
    import pixel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = PIX_DATA_WIDTH,
    parameter int DEPTH        = PIX_DEPTH,
    parameter int NUM_ENGINES  = PIX_NUM_ENGINES,
    parameter int AFULL_THRESH = DEPTH - NUM_ENGINES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*NUM_ENGINES-1:0] wr_data,
    input  logic [NUM_ENGINES-1:0]            wr_valid,
    output logic [NUM_ENGINES-1:0]            wr_ready,
    output logic                              rd_valid,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              rd_ready,
    output logic [lvl_w(DEPTH)-1:0]           level,
    output logic                              afull,
`ifdef PIXEL_FIFO_STATS_EN
    output logic                              full,
    output logic [15:0]                       stall_cnt,
    output logic [lvl_w(DEPTH)-1:0]           hwm
`else
    output logic                              full
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam int RW = idx_w(NUM_ENGINES);
    localparam int CW = cnt_w(NUM_ENGINES);

    logic [DATA_WIDTH-1:0]       mem_q [DEPTH];
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]               level_q, level_d, free;
    logic [RW-1:0]               rr_ptr_q, rr_ptr_d;
    logic [NUM_ENGINES-1:0]      grant;
    logic [NUM_ENGINES*PW-1:0]   offset;
    logic [CW-1:0]               grant_cnt;
    logic [PW-1:0]               waddr [NUM_ENGINES];
    logic                        pop;

    // A same-cycle pop does not free a slot, keeping pop off the grant path.
    assign free = LW'(DEPTH) - level_q;

    pixel_fifo_rr_alloc #(
        .NUM_ENGINES (NUM_ENGINES),
        .OFF_W       (PW),
        .FREE_W      (LW)
    ) u_alloc (
        .req_i     (wr_valid),
        .rr_ptr_i  (rr_ptr_q),
        .free_i    (free),
        .grant_o   (grant),
        .offset_o  (offset),
        .count_o   (grant_cnt),
        .rr_next_o (rr_ptr_d)
    );

    assign wr_ready = reset ? grant : '0;
    assign pop      = rd_ready && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(grant_cnt);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(grant_cnt) - LW'(pop);
        for (int i = 0; i < NUM_ENGINES; i++)
            waddr[i] = wr_ptr_q + offset[i*PW +: PW];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage is never cleared; wr_ready is already gated off during reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENGINES; i++)
            if (wr_ready[i])
                mem_q[waddr[i]] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = level_q != '0;
    assign level    = level_q;
    assign afull    = level_q >= LW'(AFULL_THRESH);
    assign full     = level_q == LW'(DEPTH);

`ifdef PIXEL_FIFO_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [16:0] stall_sum;
    logic [LW-1:0] hwm_q, hwm_d;

    always_comb begin
        stall_sum = {1'b0, stall_q} + 17'($countones(wr_valid & ~wr_ready));
        stall_d   = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
        hwm_d     = (level_d > hwm_q) ? level_d : hwm_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            hwm_q   <= '0;
        end else begin
            stall_q <= stall_d;
            hwm_q   <= hwm_d;
        end
    end

    assign stall_cnt = stall_q;
    assign hwm       = hwm_q;
`endif

endmodule

// File: doc/pixel_fifo_mw.md
Name: pixel_fifo_mw

Overview:
- Multi-writer, single-reader pixel FIFO that merges results from NUM_ENGINES Mandelbrot engines into one ordered stream for the pixel writer / framebuffer path.
- Successor to the single-grant multi-write FIFO. Adds the following:
  - a per-engine valid/ready handshake with round-robin allocation when free slots are fewer than requests;
  - a first-word-fall-through read port;
  - fill-level and almost-full outputs;
  - power-of-two DEPTH with correct full detection.

Parameters:
- DATA_WIDTH, 20, bits per pixel record (x coordinate + iteration depth).
- DEPTH, 32, number of entries; must be a power of two, ≥ 2·NUM_ENGINES.
- NUM_ENGINES, 5, number of write channels; range 1..16.
- AFULL_THRESH, DEPTH-NUM_ENGINES, level at or above which afull asserts.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- wr_data  in  DATA_WIDTH*NUM_ENGINES  flat bus; engine i occupies bits [DATA_WIDTH*i +: DATA_WIDTH].
- wr_valid  in  NUM_ENGINES  per-engine write request.
- wr_ready  out  NUM_ENGINES  per-engine grant; a write fires when wr_valid[i] && wr_ready[i].
- rd_valid  out  1  head entry valid (FIFO not empty).
- rd_data  out  DATA_WIDTH  head entry, FWFT.
- rd_ready  in  1  consumer pop; a pop fires when rd_valid && rd_ready.
- level  out  $clog2(DEPTH+1)  current occupancy.
- afull  out  1  level >= AFULL_THRESH.
- full  out  1  level == DEPTH.

Behaviour:
- Reset (reset==0 at the edge):
  - wr_ptr, rd_ptr, level and rr_ptr all go to 0.
  - rd_valid=0, afull=0, full=0. wr_ready is 0 while reset is low.
  - Memory contents are not cleared. rd_data is don't-care while rd_valid=0.
  - Reset mid-operation discards all entries, including writes and pops presented in that cycle.
- Free slots: free = DEPTH - level.
  - A pop in the same cycle does NOT add a slot. This is deliberate, to keep the timing path short.
- Allocation (combinational, per cycle):
  - Scan engines in order rr_ptr, rr_ptr+1, ... (mod NUM_ENGINES).
  - Grant the first min(free, popcount(wr_valid)) requesters found in that order.
  - wr_ready[i] depends on wr_valid. Engines must hold wr_valid and wr_data stable until granted and must not wait on wr_ready before raising wr_valid.
- Write ordering:
  - Granted records are written to consecutive addresses starting at wr_ptr, in scan order.
  - wr_ptr advances by the grant count, modulo DEPTH (natural wrap of the $clog2(DEPTH)-bit pointer).
- Round-robin pointer:
  - If any grant occurs, rr_ptr becomes (last granted index + 1) mod NUM_ENGINES.
  - With no grants, rr_ptr holds.
- Read:
  - rd_data = mem[rd_ptr]; rd_valid = (level != 0).
  - On a pop, rd_ptr increments with wrap.
- Level:
  - level_next = level + grants - pop.
  - A simultaneous pop and writes in the same cycle are both applied.
- Latency: a record written at edge N is visible at the head (if the FIFO was empty) from edge N, i.e. rd_valid is high in cycle N+1. This gives one-cycle write-to-read latency.
- Flags: full and afull are registered-equivalent, i.e. derived from the level register only.
- Illegal-case behaviour:
  - A pop while empty is ignored.
  - Writes are never accepted beyond free, so there is no overflow path.

Optional Feature:
- PIXEL_FIFO_STATS_EN defined: adds two outputs.
  - stall_cnt (16 bits): increments by popcount(wr_valid & ~wr_ready) each cycle, saturating at 0xFFFF.
  - hwm (level width): tracks the maximum level seen since reset.
  - Both clear on reset.
- Not defined: neither port exists, and no counter logic is generated.

Decomposition:
- Package pixel_fifo_pkg holds:
  - the localparam functions for pointer and level widths ($clog2 wrappers);
  - the typedef for the pixel record, pixel_rec_t {x, depth};
  - the default DATA_WIDTH, DEPTH and NUM_ENGINES constants shared with the engine array.
- Sub-module pixel_fifo_rr_alloc: combinational.
  - Inputs: req, rr_ptr, free.
  - Outputs: grant vector, per-grant write offset, grant count, next rr_ptr.
  - The FIFO top holds storage, pointers, level and flags.

Test Plan:
1. Reset, then a single write from engine 2 with data 0x00ABC → wr_ready=00100, level=1 next cycle, rd_valid=1, rd_data=0x00ABC. Pop → level=0, rd_valid=0.
2. All 5 engines valid, FIFO empty, rr_ptr=0 → all granted. Memory order is engines 0,1,2,3,4, level=5, rr_ptr=0. Popping 5 times returns records in engine order.
3. Fill to level=30 (free=2), all 5 engines valid, rr_ptr=3 → engines 3 and 4 granted, level=32, full=1, rr_ptr=0. Next cycle with no pop → wr_ready=0.
4. Level=32, all engines valid, rd_ready=1 → pop fires, no grants that cycle, level=31. Next cycle: 1 grant to the engine at rr_ptr, and level stays 31 if the pop continues.
5. Wrap-around: stream 100 records with random valid/ready. Scoreboard confirms order and zero loss, and afull=1 exactly when level≥27.
6. Reset asserted at level=12 with writes pending → next cycle level=0, rd_valid=0, wr_ready=0. After reset release, the first write lands at address 0.
